// File: rtl/kmult_pkg.sv
// Shared constants, state encoding and the Karatsuba recombination helper
// for the serial 64x64 multiplier.
package kmult_pkg;

    localparam int OP_W    = 64;
    localparam int IN_W    = 4;
    localparam int OUT_W   = 8;
    localparam int NIBBLES = 16;
    localparam int BYTES   = 16;

    localparam logic [OUT_W-1:0] IDLE_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        SEND
    } state_t;

    typedef logic [OP_W-1:0]   operand_t;
    typedef logic [2*OP_W-1:0] product_t;

    // The middle term zm-z2-z0 is always non-negative and fits in 66 bits.
    function automatic product_t kmult_combine(
        input logic [65:0] z2,
        input logic [65:0] zm,
        input logic [65:0] z0
    );
        logic [65:0] mid;
        mid = zm - z2 - z0;
        return (product_t'(z2) << 64) + (product_t'(mid) << 32) + product_t'(z0);
    endfunction

endpackage

// File: rtl/kmult_mul33.sv
// Registered 33x33 unsigned multiplier, time-shared across the three
// Karatsuba partial products.
module kmult_mul33 (
    input  logic        clk,
    input  logic        rst,
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic [65:0] p
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            p <= '0;
        end else begin
            p <= {33'b0, a} * {33'b0, b};
        end
    end

endmodule

// File: rtl/karatsuba_serial_mult.sv
// 64x64 unsigned multiplier: nibble-serial load, one-level Karatsuba on a
// shared 33x33 multiplier, byte-serial output. KMULT_OUT_VALID_EN adds out_valid.
module karatsuba_serial_mult
    import kmult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             T_Ready,
    input  logic [IN_W-1:0]  Data_in1,
    input  logic [IN_W-1:0]  Data_in2,
    output logic [OUT_W-1:0] Data_out
`ifdef KMULT_OUT_VALID_EN
    ,
    output logic             out_valid
`endif
);

    state_t        state_reg, state_next;
    operand_t      a_reg, b_reg;
    product_t      product_reg;
    logic [65:0]   z0_reg, z2_reg, zm_reg;
    logic [3:0]    cnt_reg;
    logic [3:0]    byte_next;
    logic [7:0]    data_out_reg;
    logic [32:0]   mul_a, mul_b;
    logic [32:0]   a_sum, b_sum;
    logic [65:0]   mul_p;
    product_t      p_full;

    assign a_sum     = {1'b0, a_reg[63:32]} + {1'b0, a_reg[31:0]};
    assign b_sum     = {1'b0, b_reg[63:32]} + {1'b0, b_reg[31:0]};
    assign p_full    = kmult_combine(z2_reg, zm_reg, z0_reg);
    assign byte_next = cnt_reg + 4'd1;

    // Operand select: product for step n is ready at mul_p during step n+1.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state_reg == COMPUTE) begin
            case (cnt_reg)
                4'd0: begin
                    mul_a = {1'b0, a_reg[31:0]};
                    mul_b = {1'b0, b_reg[31:0]};
                end
                4'd1: begin
                    mul_a = {1'b0, a_reg[63:32]};
                    mul_b = {1'b0, b_reg[63:32]};
                end
                4'd2: begin
                    mul_a = a_sum;
                    mul_b = b_sum;
                end
                default: ;
            endcase
        end
    end

    kmult_mul33 u_mul (
        .clk (clk),
        .rst (rst),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (cnt_reg == 4'd1) state_next = COMPUTE;
            COMPUTE: if (cnt_reg == 4'd4) state_next = SEND;
            SEND:    if (T_Ready && cnt_reg == 4'(BYTES - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg        <= '0;
            b_reg        <= '0;
            product_reg  <= '0;
            z0_reg       <= '0;
            z2_reg       <= '0;
            zm_reg       <= '0;
            cnt_reg      <= '0;
            data_out_reg <= IDLE_BYTE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg   <= {60'b0, Data_in1};
                        b_reg   <= {60'b0, Data_in2};
                        cnt_reg <= 4'(NIBBLES - 1);
                    end
                end
                LOAD: begin
                    a_reg   <= {a_reg[59:0], Data_in1};
                    b_reg   <= {b_reg[59:0], Data_in2};
                    cnt_reg <= cnt_reg - 4'd1;
                end
                COMPUTE: begin
                    cnt_reg <= cnt_reg + 4'd1;
                    case (cnt_reg)
                        4'd1: z0_reg <= mul_p;
                        4'd2: z2_reg <= mul_p;
                        4'd3: zm_reg <= mul_p;
                        4'd4: begin
                            product_reg  <= p_full;
                            data_out_reg <= p_full[7:0];
                            cnt_reg      <= '0;
                        end
                        default: ;
                    endcase
                end
                SEND: begin
                    if (T_Ready) begin
                        if (cnt_reg == 4'(BYTES - 1)) begin
                            data_out_reg <= IDLE_BYTE;
                            cnt_reg      <= '0;
                        end else begin
                            data_out_reg <= product_reg[{byte_next, 3'b000} +: 8];
                            cnt_reg      <= byte_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign Data_out = data_out_reg;

`ifdef KMULT_OUT_VALID_EN
    assign out_valid = (state_reg == SEND);
`endif

endmodule

// File: tb/tb_karatsuba_serial_mult.sv
// Self-checking bench for karatsuba_serial_mult: directed table, stall and
// reset sequences, random pairs vs plain 128-bit multiplication.
module tb_karatsuba_serial_mult;

    typedef logic [63:0]  op_t;
    typedef logic [127:0] prod_t;

    typedef struct {
        op_t   a;
        op_t   b;
        prod_t expected;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       T_Ready = 1'b0;
    logic [3:0] Data_in1 = '0;
    logic [3:0] Data_in2 = '0;
    logic [7:0] Data_out;
`ifdef KMULT_OUT_VALID_EN
    logic       out_valid;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    karatsuba_serial_mult dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .T_Ready  (T_Ready),
        .Data_in1 (Data_in1),
        .Data_in2 (Data_in2),
        .Data_out (Data_out)
`ifdef KMULT_OUT_VALID_EN
        ,
        .out_valid(out_valid)
`endif
    );

    function automatic prod_t ref_mult(input op_t a, input op_t b);
        return prod_t'(a) * prod_t'(b);
    endfunction

    task automatic check128(input string name, input prod_t act, input prod_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %032h expected %032h", name, act, exp);
        end else begin
            $display("ok   %s: %032h", name, act);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Caller is at #1 after an edge with the DUT idle.
    task automatic run_op(input op_t a, input op_t b, input bit stall,
                          input bit noise, output prod_t got);
        logic [7:0] held;
        int beats;
        beats = 0;
        got = '0;
        start = 1'b1;
        Data_in1 = a[63:60];
        Data_in2 = b[63:60];
        for (int i = 14; i >= 0; i--) begin
            @(posedge clk); #1;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            Data_in1 = a[4*i +: 4];
            Data_in2 = b[4*i +: 4];
        end
        @(posedge clk); #1;
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        Data_in1 = 4'($urandom);
        Data_in2 = 4'($urandom);
        T_Ready = 1'($urandom_range(0, 1));
        repeat (4) @(posedge clk);
        #1;
        check8("compute_idle_byte", Data_out, 8'hFF);
        start = 1'b0;
        @(posedge clk); #1;
        T_Ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (stall && k == 7) begin
                T_Ready = 1'b0;
                held = Data_out;
                repeat (3) begin
                    @(posedge clk); #1;
                    check8("stall_hold", Data_out, held);
                end
                T_Ready = 1'b1;
            end
            got[8*k +: 8] = Data_out;
`ifdef KMULT_OUT_VALID_EN
            if (out_valid === 1'b1) beats++;
`endif
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
        end
        T_Ready = 1'b0;
        check8("idle_after_send", Data_out, 8'hFF);
`ifdef KMULT_OUT_VALID_EN
        check8("out_valid_beats", 8'(beats), 8'd16);
        check8("out_valid_low", {7'b0, out_valid}, 8'd0);
`endif
    endtask

    vec_t  table_v[5];
    prod_t got;
    op_t   ra, rb;

    initial begin
        table_v[0] = '{64'h1, 64'h8, 128'd8};
        table_v[1] = '{64'h2, 64'h3, 128'd6};
        table_v[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                       128'hFFFFFFFFFFFFFFFE0000000000000001};
        table_v[3] = '{64'hFAFAFAFAFAFAFAFA, 64'hFAFAFAFAFAFAFAFA,
                       ref_mult(64'hFAFAFAFAFAFAFAFA, 64'hFAFAFAFAFAFAFAFA)};
        table_v[4] = '{64'h1000000000000000, 64'h1000000000000000,
                       128'h01000000000000000000000000000000};

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check8("reset_data_out", Data_out, 8'hFF);
`ifdef KMULT_OUT_VALID_EN
        check8("reset_out_valid", {7'b0, out_valid}, 8'd0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        check8("idle_no_start", Data_out, 8'hFF);

        for (int v = 0; v < 5; v++) begin
            run_op(table_v[v].a, table_v[v].b, 1'b0, 1'b0, got);
            check128($sformatf("table_%0d", v), got, table_v[v].expected);
            if (v == 0) check8("table_0_byte0", got[7:0], 8'h08);
        end

        // Reset during COMPUTE aborts; next op must work.
        ra = {$urandom, $urandom};
        start = 1'b1;
        Data_in1 = ra[63:60];
        Data_in2 = ra[59:56];
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check8("abort_data_out", Data_out, 8'hFF);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check8("abort_no_output", Data_out, 8'hFF);

        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        run_op(ra, rb, 1'b1, 1'b0, got);
        check128("after_abort_stall", got, ref_mult(ra, rb));

        for (int r = 0; r < 20; r++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (r % 5 == 1) ra[63:32] = 32'hFFFFFFFF;
            if (r % 5 == 2) rb[31:0]  = 32'hFFFFFFFF;
            run_op(ra, rb, (r % 4) == 0, 1'b1, got);
            check128($sformatf("random_%0d a=%016h b=%016h", r, ra, rb), got, ref_mult(ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
